// File: rtl/mips_pipe_defs.sv
// Shared pipeline definitions: skid-stage state encodings.
package mips_pipe_defs;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam logic [1:0] SKID_OCC_EMPTY = 2'd0;
  localparam logic [1:0] SKID_OCC_BUSY  = 2'd1;
  localparam logic [1:0] SKID_OCC_FULL  = 2'd2;

endpackage

// File: rtl/en_register.sv
// Load-enable payload register with asynchronous active-high reset to zero.
module en_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages; in_ready and out_valid are
// registered so no combinational ready path crosses the stage.
//
// state      | meaning
// SKID_EMPTY | no entries held; in_ready=1, out_valid=0
// SKID_BUSY  | main register holds the head word
// SKID_FULL  | main holds head, skid holds next word; in_ready=0
module pipe_skid_stage
  import mips_pipe_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occupancy_q;
  logic             in_fire;
  logic             out_fire;
  logic             main_ld;
  logic             skid_ld;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Payload loads are suppressed on flush so a flushed input never lands.
  always_comb begin
    main_ld = 1'b0;
    skid_ld = 1'b0;
    if (!flush) begin
      unique case (state_q)
        SKID_EMPTY: main_ld = in_fire;
        SKID_BUSY: begin
          main_ld = in_fire & out_fire;
          skid_ld = in_fire & ~out_fire;
        end
        SKID_FULL: main_ld = out_fire;
        default: begin
          main_ld = 1'b0;
          skid_ld = 1'b0;
        end
      endcase
    end
  end

  assign main_d = (state_q == SKID_FULL) ? skid_q : in_data;

  en_register #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  en_register #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .ld_i  (skid_ld),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= SKID_OCC_EMPTY;
    end else if (flush) begin
      state_q     <= SKID_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= SKID_OCC_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            state_q     <= SKID_BUSY;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
            occupancy_q <= SKID_OCC_BUSY;
          end
        end
        SKID_BUSY: begin
          if (in_fire && !out_fire) begin
            state_q     <= SKID_FULL;
            in_ready_q  <= 1'b0;
            occupancy_q <= SKID_OCC_FULL;
          end else if (!in_fire && out_fire) begin
            state_q     <= SKID_EMPTY;
            out_valid_q <= 1'b0;
            occupancy_q <= SKID_OCC_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            state_q     <= SKID_BUSY;
            in_ready_q  <= 1'b1;
            occupancy_q <= SKID_OCC_BUSY;
          end
        end
        default: begin
          state_q     <= SKID_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occupancy_q <= SKID_OCC_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occupancy_q;

endmodule
